hazard_unit: RTL
================

# hazard_unit

- Generates the forwarding selects that drive the execute-stage operand muxes: ForwardAE/ForwardBE, encoded 00 = RD1/RD2, 01 = ResultW, 10 = ALUOutM.
- Also generates the decode-stage branch-compare forwards and the pipeline stall/flush controls.
- Sequential content:
  - multiply/divide busy counter, which enforces structural stalls on HI/LO access;
  - saturating performance counters for stall and branch-flush cycles.
- Sits beside the five-stage datapath; consumes register specifiers and control bits from stages D, E, M and W.

## Interface

Parameters:
- MD_LATENCY, 8, cycles a multiply/divide occupies the HI/LO unit after issue (1..255)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- RsD, RtD  in  5 each  source registers of the instruction in D
- RsE, RtE  in  5 each  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination-write enables
- MemtoRegE, MemtoRegM  in  1 each  the instruction in that stage is a load
- BranchD  in  1  D holds a branch that compares in D
- PCSrcD  in  1  branch in D resolved taken
- MultDivD  in  1  D holds a mult/div
- MfhiloD  in  1  D holds mfhi/mflo
- MDStartE  in  1  a mult/div is in E this cycle (issue pulse)
- ForwardAE, ForwardBE  out  2 each  E operand selects
- ForwardAD, ForwardBD  out  1 each  D comparator select: 1 = ALUOutM
- StallF, StallD  out  1 each  hold the PC and IF/ID registers
- FlushE  out  1  clear the ID/EX register (bubble)
- FlushD  out  1  clear the IF/ID register (taken branch)
- MdBusy  out  1  HI/LO unit occupied
- StallCount  out  CNT_W  cycles with StallD = 1
- FlushCount  out  CNT_W  cycles with FlushD = 1

## Operation

Register 0 is never a hazard. Every match term below requires the compared source register to be nonzero.

E-stage forwarding (ForwardAE shown; ForwardBE is identical with RtE):
- 10 if RsE == WriteRegM and RegWriteM.
- Otherwise 01 if RsE == WriteRegW and RegWriteW.
- Otherwise 00.
- M has priority over W. Code 11 is never produced.

D-stage forwarding:
- ForwardAD = RsD == WriteRegM and RegWriteM.
- ForwardBD is identical with RtD.

Stall terms:
- lwstall = MemtoRegE and RegWriteE and WriteRegE matches RsD or RtD.
- branchstall = BranchD and either:
  - RegWriteE and WriteRegE matches RsD or RtD; or
  - MemtoRegM and WriteRegM matches RsD or RtD.
- mdstall = MdBusy and (MultDivD or MfhiloD).
- stall = lwstall or branchstall or mdstall.

Control outputs:
- StallF = StallD = FlushE = stall.
- FlushD = PCSrcD and not stall.

Multiply/divide counter md_cnt (8 bits):
- Reset to 0.
- If md_cnt == 0 and MDStartE, load MD_LATENCY.
- Else if md_cnt != 0, decrement by 1.
- MDStartE while md_cnt != 0 is ignored; the counter keeps decrementing.
- MdBusy = (md_cnt != 0), decoded from the register (glitch-free).

Performance counters:
- StallCount increments on each clock edge where stall = 1.
- FlushCount increments on each clock edge where FlushD = 1.
- Both saturate at 2^CNT_W − 1 and never wrap.

While reset is high:
- md_cnt and both counters are held at 0.
- All stall, flush and forward outputs are forced to 0.

## Timing

- All forward, stall and flush outputs are combinational from the current-cycle inputs and md_cnt: zero latency, valid before the same clock edge.
- MdBusy rises the cycle after the MDStartE edge and stays high exactly MD_LATENCY cycles.
- A D-stage HI/LO reader first proceeds in the cycle in which MdBusy = 0.
- Counters update one edge after the qualifying cycle.
- Reset values: md_cnt = 0, MdBusy = 0, StallCount = 0, FlushCount = 0; all combinational outputs are 0.
- Reset asserted mid-busy clears md_cnt asynchronously; MdBusy drops immediately, without waiting for a clock edge.
- Simultaneous lwstall and mdstall: a single stall. StallCount increments once per cycle, not per cause.
- Stall and PCSrcD in the same cycle: FlushD = 0. The branch is re-evaluated after the stall clears.

## Test plan

- Forward priority: RsE = 5, WriteRegM = 5, RegWriteM = 1, WriteRegW = 5, RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → 01. Set RsE = 0 with all writes matching → 00.
- Load-use: MemtoRegE = 1, RegWriteE = 1, WriteRegE = 8, RtD = 8 → StallF = StallD = FlushE = 1 for that cycle; StallCount goes 0 → 1 at the next edge.
- Branch hazard: BranchD = 1, RsD = 3, RegWriteE = 1, WriteRegE = 3 → stall = 1. Next cycle, same register now in M with MemtoRegM = 0 and RegWriteM = 1 → stall = 0, ForwardAD = 1.
- Mult/div, MD_LATENCY = 4: pulse MDStartE, then hold MfhiloD = 1 → MdBusy high for 4 cycles, stall for those 4 cycles, 0 afterwards; a second MDStartE while busy does not extend the count.
- Taken branch: PCSrcD = 1 with no stall → FlushD = 1 and FlushCount increments. With lwstall also true → FlushD = 0.
- Reset at md_cnt = 2 → MdBusy = 0 without a clock edge, counters read 0. Force StallCount to its maximum → it stays saturated.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage pipeline: operand forwarding selects, stall/flush
// control, a HI/LO busy counter for multiply/divide and saturating stall/flush counters.
module hazard_unit #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             MultDivD,
    input  logic             MfhiloD,
    input  logic             MDStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             FlushD,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY);

    logic [7:0] md_cnt;
    logic       lwstall;
    logic       branchstall;
    logic       mdstall;
    logic       stall;
    logic       flush_d;

    // Register 0 is hardwired, so a match against it is never a hazard.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wr_m, input logic we_m,
                                           input logic [4:0] wr_w, input logic we_w);
        if (we_m && reg_match(src, wr_m))
            return 2'b10;
        else if (we_w && reg_match(src, wr_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        lwstall     = MemtoRegE && RegWriteE &&
                      (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE));
        branchstall = BranchD &&
                      ((RegWriteE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE))) ||
                       (MemtoRegM && (reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM))));
        mdstall     = MdBusy && (MultDivD || MfhiloD);
        stall       = !reset && (lwstall || branchstall || mdstall);
        flush_d     = !reset && PCSrcD && !stall;
    end

    // Every combinational control is forced quiet while reset is held.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
            ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
            ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
            ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);
        end
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = flush_d;
    assign MdBusy = (md_cnt != 8'd0);

    // An issue while the unit is busy is dropped; the running count is never extended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= 8'd0;
        else if (md_cnt == 8'd0) begin
            if (MDStartE)
                md_cnt <= MD_LOAD;
        end else
            md_cnt <= md_cnt - 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall && (StallCount != '1))
                StallCount <= StallCount + CNT_W'(1);
            if (flush_d && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule
